// File: rtl/dma_fifo_bridge.sv
// -----------------------------------------------------------------------------
// dma_fifo_bridge
//   Single-channel DMA engine between a peripheral device and the openMSP430
//   DMA memory port. Words are staged in an internal circular FIFO of
//   2^FIFO_DEPTH entries. Transfers move in FIFO-sized chunks. In read mode
//   (rd_wr=1) memory words go to the device. In write mode (rd_wr=0) device
//   words go to memory.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   rqst              device transfer request; rd_wr/num_words/start_addr
//                     are latched with it while idle
//   dev_ack / dma_ack device-side handshake (strobe in / strobe out)
//   dev_in / dev_out  device data (write mode in / read mode out)
//   end_flag          one-cycle pulse when a transfer finishes or aborts
//   dma_*             openMSP430 DMA memory port. dma_en/dma_addr are held
//                     until dma_ready. dma_resp flags an error.
//
// Parameter FIFO_DIV_FACTOR names an early-drain threshold. The chunked
// schedule implemented here only switches phase on FIFO full/empty, so the
// threshold does not affect behaviour.
//
// Optional build macro DMA_STATE_DEBUG_EN adds two outputs: dbg_state (the
// current state encoding) and dbg_fifo_cnt (the FIFO occupancy).
// -----------------------------------------------------------------------------
module dma_fifo_bridge #(
    parameter int ADD_LEN         = 5,
    parameter int DATA_LEN        = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_DIV_FACTOR = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rqst,
    input  logic                  rd_wr,
    input  logic [FIFO_DEPTH:0]   num_words,
    input  logic [ADD_LEN-1:0]    start_addr,
    input  logic                  dev_ack,
    input  logic [DATA_LEN-1:0]   dev_in,
    output logic                  dma_ack,
    output logic [DATA_LEN-1:0]   dev_out,
    output logic                  end_flag,
    input  logic [DATA_LEN-1:0]   dma_in,
    input  logic                  dma_ready,
    input  logic                  dma_resp,
    output logic [ADD_LEN-1:0]    dma_addr,
    output logic [DATA_LEN-1:0]   dma_out,
    output logic                  dma_en,
    output logic                  dma_priority,
    output logic [1:0]            dma_we
`ifdef DMA_STATE_DEBUG_EN
    ,
    output logic [4:0]            dbg_state,
    output logic [FIFO_DEPTH:0]   dbg_fifo_cnt
`endif
);

    localparam int ENTRIES = 2 ** FIFO_DEPTH;

    localparam logic [4:0] S_IDLE     = 5'd0;
    localparam logic [4:0] S_GET_REGS = 5'd1;
    localparam logic [4:0] S_RD_MEM   = 5'd2;
    localparam logic [4:0] S_RD_DEV   = 5'd3;
    localparam logic [4:0] S_WR_DEV   = 5'd4;
    localparam logic [4:0] S_WR_MEM   = 5'd5;
    localparam logic [4:0] S_DONE     = 5'd6;
    localparam logic [4:0] S_ERROR    = 5'd7;

    localparam logic [FIFO_DEPTH:0]   CNT_ONE  = (FIFO_DEPTH+1)'(1'b1);
    localparam logic [FIFO_DEPTH:0]   CNT_FULL = CNT_ONE << FIFO_DEPTH;
    localparam logic [FIFO_DEPTH-1:0] PTR_ONE  = FIFO_DEPTH'(1'b1);
    localparam logic [ADD_LEN-1:0]    ADDR_ONE = ADD_LEN'(1'b1);

    logic [4:0]            state_q, state_d;
    logic                  rd_wr_q, rd_wr_d;
    logic [ADD_LEN-1:0]    addr_q, addr_d;
    // mem_left: words still to be fetched from memory (read mode)
    logic [FIFO_DEPTH:0]   mem_left_q, mem_left_d;
    // dev_left: words still to be exchanged with the device (both modes)
    logic [FIFO_DEPTH:0]   dev_left_q, dev_left_d;
    // cap_pend: a read was accepted last cycle; dma_in is valid now
    logic                  cap_pend_q, cap_pend_d;
    logic [FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH:0]   fifo_cnt_q, fifo_cnt_d;
    logic [DATA_LEN-1:0]   fifo_mem [0:ENTRIES-1];

    logic                  fifo_full_s, fifo_empty_s;
    logic                  rd_issue_s, wr_issue_s, accept_s;
    logic                  push_s, pop_s;
    logic [DATA_LEN-1:0]   push_data_s, head_s;

    assign fifo_full_s  = (fifo_cnt_q == CNT_FULL);
    assign fifo_empty_s = (fifo_cnt_q == '0);
    assign head_s       = fifo_mem[rd_ptr_q];

    // A read request is only issued when no capture is outstanding, so the
    // FIFO count seen by the full check already includes every fetched word.
    assign rd_issue_s  = (state_q == S_RD_MEM) && !cap_pend_q && !fifo_full_s
                         && (mem_left_q != '0);
    assign wr_issue_s  = (state_q == S_WR_MEM) && !fifo_empty_s;
    assign accept_s    = (rd_issue_s || wr_issue_s) && dma_ready && !dma_resp;
    assign push_s      = ((state_q == S_RD_MEM) && cap_pend_q)
                         || ((state_q == S_WR_DEV) && !fifo_full_s
                             && (dev_left_q != '0) && dev_ack);
    assign push_data_s = (state_q == S_RD_MEM) ? dma_in : dev_in;
    assign pop_s       = ((state_q == S_RD_DEV) && !fifo_empty_s && dev_ack)
                         || (wr_issue_s && dma_ready && !dma_resp);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rqst) begin
                    state_d = S_GET_REGS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GET_REGS: begin
                if (dev_left_q == '0) begin
                    state_d = S_DONE;
                end else if (rd_wr_q) begin
                    state_d = S_RD_MEM;
                end else begin
                    state_d = S_WR_DEV;
                end
            end
            S_RD_MEM: begin
                if (cap_pend_q) begin
                    state_d = S_RD_MEM;
                end else if (fifo_full_s || (mem_left_q == '0)) begin
                    state_d = S_RD_DEV;
                end else if (dma_ready && dma_resp) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_RD_MEM;
                end
            end
            S_RD_DEV: begin
                if (dev_left_q == '0) begin
                    state_d = S_DONE;
                end else if (fifo_empty_s) begin
                    state_d = S_RD_MEM;
                end else begin
                    state_d = S_RD_DEV;
                end
            end
            S_WR_DEV: begin
                if (fifo_full_s || (dev_left_q == '0)) begin
                    state_d = S_WR_MEM;
                end else begin
                    state_d = S_WR_DEV;
                end
            end
            S_WR_MEM: begin
                if (fifo_empty_s) begin
                    if (dev_left_q != '0) begin
                        state_d = S_WR_DEV;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (dma_ready && dma_resp) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_WR_MEM;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode (pure function of registered state)
    always_comb begin
        dma_en       = rd_issue_s || wr_issue_s;
        dma_addr     = (rd_issue_s || wr_issue_s) ? addr_q : '0;
        dma_we       = wr_issue_s ? 2'b11 : 2'b00;
        dma_out      = wr_issue_s ? head_s : '0;
        dma_priority = (rd_issue_s && fifo_empty_s) || (wr_issue_s && fifo_full_s);
        dma_ack      = ((state_q == S_RD_DEV) && !fifo_empty_s)
                       || ((state_q == S_WR_DEV) && !fifo_full_s && (dev_left_q != '0));
        dev_out      = ((state_q == S_RD_DEV) && !fifo_empty_s) ? head_s : '0;
        end_flag     = (state_q == S_DONE) || (state_q == S_ERROR);
    end

    // Datapath next-state: transfer parameters, counters and FIFO pointers
    always_comb begin
        rd_wr_d    = rd_wr_q;
        addr_d     = addr_q;
        mem_left_d = mem_left_q;
        dev_left_d = dev_left_q;
        cap_pend_d = cap_pend_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if ((state_q == S_IDLE) && rqst) begin
            // New transfer starts from an empty FIFO whatever an aborted
            // transfer left behind.
            rd_wr_d    = rd_wr;
            addr_d     = start_addr;
            mem_left_d = num_words;
            dev_left_d = num_words;
            cap_pend_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (accept_s) begin
                addr_d = addr_q + ADDR_ONE;
                if (rd_issue_s) begin
                    mem_left_d = mem_left_q - CNT_ONE;
                    cap_pend_d = 1'b1;
                end else begin
                    mem_left_d = mem_left_q;
                end
            end else begin
                addr_d = addr_q;
            end
            // Push and pop belong to exclusive phases and never coincide.
            if (push_s) begin
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
                fifo_cnt_d = fifo_cnt_q + CNT_ONE;
                cap_pend_d = 1'b0;
                if (state_q == S_WR_DEV) begin
                    dev_left_d = dev_left_q - CNT_ONE;
                end else begin
                    dev_left_d = dev_left_q;
                end
            end else if (pop_s) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                fifo_cnt_d = fifo_cnt_q - CNT_ONE;
                if (state_q == S_RD_DEV) begin
                    dev_left_d = dev_left_q - CNT_ONE;
                end else begin
                    dev_left_d = dev_left_q;
                end
            end else begin
                fifo_cnt_d = fifo_cnt_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_wr_q    <= 1'b0;
            addr_q     <= '0;
            mem_left_q <= '0;
            dev_left_q <= '0;
            cap_pend_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            rd_wr_q    <= rd_wr_d;
            addr_q     <= addr_d;
            mem_left_q <= mem_left_d;
            dev_left_q <= dev_left_d;
            cap_pend_q <= cap_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= push_data_s;
        end
    end

`ifdef DMA_STATE_DEBUG_EN
    assign dbg_state    = state_q;
    assign dbg_fifo_cnt = fifo_cnt_q;
`endif

endmodule

// File: tb/tb_dma_fifo_bridge.sv
module tb_dma_fifo_bridge;

    localparam int FULL = 16;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rqst, rd_wr, dev_ack, dma_ready, dma_resp;
    logic [4:0] num_words;
    logic [4:0] start_addr;
    logic [7:0] dev_in, dma_in;
    logic       dma_ack, end_flag, dma_en, dma_priority;
    logic [7:0] dev_out, dma_out;
    logic [4:0] dma_addr;
    logic [1:0] dma_we;

    dma_fifo_bridge dut (
        .clk(clk), .reset(reset), .rqst(rqst), .rd_wr(rd_wr),
        .num_words(num_words), .start_addr(start_addr),
        .dev_ack(dev_ack), .dev_in(dev_in), .dma_ack(dma_ack),
        .dev_out(dev_out), .end_flag(end_flag), .dma_in(dma_in),
        .dma_ready(dma_ready), .dma_resp(dma_resp), .dma_addr(dma_addr),
        .dma_out(dma_out), .dma_en(dma_en), .dma_priority(dma_priority),
        .dma_we(dma_we)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mem [0:31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // ---------------- reference model / compare process ----------------
    bit   chk_on = 0;
    bit   busy = 0, m_rw = 0, err_seen = 0, prev_stall = 0, got_dlv = 0;
    int   m_cnt, m_sa, fetched, captured, delivered, received, written, cap_cnt;
    int   ncyc = 0, t0, n_acc, n_end, end_lat, first_dev, first_wr_data, first_wr_addr, fetched_at_dlv;
    logic [4:0] prev_addr;
    logic [7:0] recvq [$];

    initial forever begin
        @(negedge clk);
        ncyc++;
        if (!chk_on) begin
            prev_stall = 0;
        end else if (reset) begin
            busy = 0; prev_stall = 0;
            check("rst_en", dma_en, 0);   check("rst_ack", dma_ack, 0);
            check("rst_end", end_flag, 0); check("rst_addr", dma_addr, 0);
            check("rst_we", dma_we, 0);   check("rst_prio", dma_priority, 0);
            check("rst_devout", dev_out, 0); check("rst_dmaout", dma_out, 0);
        end else begin
            if (cap_cnt > 0) begin
                cap_cnt--;
                if (cap_cnt == 0) captured++;
            end
            if (!busy) begin
                check("idle_en", dma_en, 0);
                check("idle_ack", dma_ack, 0);
                check("idle_end", end_flag, 0);
                check("idle_prio", dma_priority, 0);
                if (rqst) begin
                    busy = 1; m_rw = rd_wr; m_cnt = num_words; m_sa = start_addr;
                    fetched = 0; captured = 0; delivered = 0; received = 0; written = 0;
                    cap_cnt = 0; err_seen = 0; got_dlv = 0; recvq.delete();
                    t0 = ncyc; n_acc = 0; n_end = 0; end_lat = -1;
                    first_dev = -1; first_wr_data = -1; first_wr_addr = -1; fetched_at_dlv = -1;
                end
            end else begin
                if (prev_stall) begin
                    check("stall_en", dma_en, 1);
                    check("stall_addr", dma_addr, prev_addr);
                end
                if (dma_en) begin
                    check("en_after_err", err_seen, 0);
                    check("we", dma_we, m_rw ? 2'b00 : 2'b11);
                    if (m_rw) check("prio_rd", dma_priority, (captured == delivered));
                    else      check("prio_wr", dma_priority, ((received - written) == FULL));
                end else begin
                    check("prio_noen", dma_priority, 0);
                end
                if (dma_en && dma_ready) begin
                    n_acc++;
                    if (dma_resp) begin
                        err_seen = 1;
                    end else if (m_rw) begin
                        check("rd_addr", dma_addr, (m_sa + fetched) % 32);
                        check("rd_refill", delivered, (fetched / FULL) * FULL);
                        check("rd_over", (fetched < m_cnt), 1);
                        fetched++; cap_cnt = 2;
                    end else begin
                        check("wr_addr", dma_addr, (m_sa + written) % 32);
                        check("wr_chunk", received, imin(m_cnt, (written / FULL + 1) * FULL));
                        check("wr_order", (written < received), 1);
                        if (written < received) check("wr_data", dma_out, recvq[written]);
                        if (written == 0) begin
                            first_wr_data = dma_out; first_wr_addr = dma_addr;
                        end
                        written++;
                    end
                end
                if (dma_ack) begin
                    if (m_rw) check("ack_nonempty", (captured > delivered), 1);
                    else      check("ack_room", ((received - written) < FULL) && (received < m_cnt), 1);
                    if (dev_ack) begin
                        if (m_rw) begin
                            check("dev_out", dev_out, mem[(m_sa + delivered) % 32]);
                            check("rd_chunk", fetched, imin(m_cnt, (delivered / FULL + 1) * FULL));
                            if (!got_dlv) begin
                                got_dlv = 1; first_dev = dev_out; fetched_at_dlv = fetched;
                            end
                            delivered++;
                        end else begin
                            check("wr_chunk_rx", written, (received / FULL) * FULL);
                            recvq.push_back(dev_in);
                            received++;
                        end
                    end
                end
                if (end_flag) begin
                    n_end++;
                    end_lat = ncyc - t0;
                    if (!err_seen) check("done_count", m_rw ? delivered : written, m_cnt);
                    busy = 0;
                end
                prev_stall = dma_en && !dma_ready;
                prev_addr  = dma_addr;
            end
        end
    end

    // ---------------- stimulus: device + memory responder ----------------
    int   acc_n = 0, err_at = -1, stall_n = 0, rdy_pct = 100, ack_pct = 100, fix_dev = -1;
    logic p_en = 0, p_rdy = 0, p_resp = 0;
    logic [1:0] p_we = 0;
    logic [4:0] p_addr = 0;
    logic [7:0] p_out = 0;

    task automatic step();
        @(posedge clk);
        #2;
        dma_in = 8'($urandom);
        if (p_en && p_rdy) begin
            acc_n++;
            if (!p_resp) begin
                if (p_we == 2'b00) dma_in = mem[p_addr];
                else               mem[p_addr] = p_out;
            end
        end
        dma_resp = 1'b0;
        if (dma_en && !reset) begin
            if (err_at >= 0 && acc_n == err_at) begin
                if (stall_n > 0) begin
                    stall_n--; dma_ready = 1'b0;
                end else begin
                    dma_ready = 1'b1; dma_resp = 1'b1;
                end
            end else begin
                dma_ready = ($urandom_range(99) < rdy_pct);
            end
        end else begin
            dma_ready = 1'($urandom_range(1));
        end
        dev_ack = ($urandom_range(99) < ack_pct);
        dev_in  = (fix_dev >= 0) ? 8'(fix_dev) : 8'($urandom);
        p_en = dma_en; p_rdy = dma_ready; p_resp = dma_resp;
        p_we = dma_we; p_addr = dma_addr; p_out = dma_out;
    endtask

    task automatic run_xfer(input logic rw, input int n, input int sa, input int rp,
                            input int ap, input int ea, input int fd);
        int budget;
        rdy_pct = rp; ack_pct = ap; err_at = ea; stall_n = 5; fix_dev = fd; acc_n = 0;
        rd_wr = rw; num_words = 5'(n); start_addr = 5'(sa); rqst = 1'b1;
        step();
        rqst = 1'b0; rd_wr = 1'($urandom); num_words = 5'($urandom); start_addr = 5'($urandom);
        budget = 1500;
        while (!end_flag && budget > 0) begin
            step();
            budget--;
        end
        check("timeout", (budget > 0), 1);
        if (budget == 0) begin
            reset = 1'b1; step(); reset = 1'b0;
        end
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rqst = 1'b1; rd_wr = 1'b1; num_words = 5'd5; start_addr = 5'd0;
        dev_ack = 1'b0; dev_in = 8'h00; dma_in = 8'h00; dma_ready = 1'b0; dma_resp = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        step();
        chk_on = 1;
        step();
        reset = 1'b0; rqst = 1'b0;
        step(); step();

        // read one word
        mem[0] = 8'hA5;
        run_xfer(1'b1, 1, 0, 100, 100, -1, -1);
        check("read1_data", first_dev, 8'hA5);
        check("read1_acc", n_acc, 1);
        check("read1_end", n_end, 1);

        // write one word
        run_xfer(1'b0, 1, 0, 100, 100, -1, 8'h3C);
        check("write1_data", first_wr_data, 8'h3C);
        check("write1_addr", first_wr_addr, 0);
        check("write1_acc", n_acc, 1);
        check("write1_mem", mem[0], 8'h3C);

        // refill: 16 + 4
        run_xfer(1'b1, 20, 0, 100, 100, -1, -1);
        check("refill_acc", n_acc, 20);
        check("refill_first_chunk", fetched_at_dlv, 16);
        check("refill_end", n_end, 1);

        // zero length
        run_xfer(1'b1, 0, 7, 100, 100, -1, -1);
        check("zero_lat", end_lat, 2);
        check("zero_acc", n_acc, 0);

        // stall then error on first read
        run_xfer(1'b1, 10, 3, 100, 100, 0, -1);
        check("err_rd_end", n_end, 1);
        check("err_rd_acc", n_acc, 1);

        // error on third write
        run_xfer(1'b0, 6, 0, 100, 100, 2, -1);
        check("err_wr_end", n_end, 1);
        check("err_wr_acc", n_acc, 3);

        // address wrap with random handshakes, then a long write
        run_xfer(1'b1, 10, 28, 70, 60, -1, -1);
        check("wrap_acc", n_acc, 10);
        run_xfer(1'b0, 31, 20, 60, 70, -1, -1);
        check("wr31_acc", n_acc, 31);

        for (int k = 0; k < 14; k++) begin
            run_xfer(1'($urandom), int'($urandom_range(31)), int'($urandom_range(31)),
                     int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), -1, -1);
            check("rand_end", n_end, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_fifo_bridge.md
Name: dma_fifo_bridge

Overview:
- Single-channel DMA engine between a peripheral device and the openMSP430 DMA memory port.
- Buffers data in an internal FIFO of 2^FIFO_DEPTH words.
- Read transfer (rd_wr=1): moves num_words words from memory at start_addr to the device.
- Write transfer (rd_wr=0): moves num_words words from the device into memory.
- Sits between the device model and the MSP430 memory-side model in the DMA subsystem.

Parameters:
ADD_LEN, 5, memory word-address width
DATA_LEN, 8, data word width
FIFO_DEPTH, 4, log2 of FIFO entries (16)
FIFO_DIV_FACTOR, 3, read-mode early-drain threshold THR = max(1, 2^FIFO_DEPTH >> FIFO_DIV_FACTOR) words

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rqst  in  1  device transfer request (level)
rd_wr  in  1  1=memory->device, 0=device->memory; sampled with rqst
num_words  in  FIFO_DEPTH+1  transfer length; sampled with rqst
start_addr  in  ADD_LEN  first memory word address; sampled with rqst
dev_ack  in  1  device handshake strobe
dev_in  in  DATA_LEN  data from device (write mode)
dma_ack  out  1  controller handshake strobe to device
dev_out  out  DATA_LEN  data to device (read mode)
end_flag  out  1  one-cycle pulse: transfer finished or aborted
dma_in  in  DATA_LEN  memory read data
dma_ready  in  1  memory access accepted this cycle
dma_resp  in  1  memory error response, valid with dma_ready
dma_addr  out  ADD_LEN  memory word address
dma_out  out  DATA_LEN  memory write data
dma_en  out  1  memory access request
dma_priority  out  1  high-priority request
dma_we  out  2  byte write enables

Behaviour:
- Reset (synchronous, active-high) forces the following, all taking effect on the next rising clk edge:
  - state IDLE;
  - FIFO and counters cleared;
  - all outputs 0.
- Reset mid-transfer aborts the transfer without an end_flag pulse.
- IDLE:
  - When rqst=1, latch rd_wr, num_words (cnt) and start_addr (addr), then go to GET_REGS.
  - In GET_REGS, cnt=0 goes directly to DONE with no memory access. Otherwise go to RD_MEM (rd_wr=1) or WR_DEV (rd_wr=0).
- Memory handshake:
  - dma_en=1 and dma_addr=addr are held until a cycle with dma_ready=1.
  - Reads: dma_we=00. dma_in is captured into the FIFO on the cycle after dma_ready.
  - Writes: dma_we=11 and dma_out=FIFO head, popped on dma_ready.
  - addr increments by 1 per accepted access and wraps modulo 2^ADD_LEN.
  - dma_ready with dma_resp=1 goes to ERROR: no data is stored or popped, end_flag pulses for one cycle, then IDLE.
- RD_MEM (read mode):
  - Fetch words until the FIFO is full or all remaining words have been fetched, then go to RD_DEV.
  - Go to RD_DEV early once FIFO count >= THR and the FIFO is not full? No: the early drain applies only at FIFO full. Exactly: RD_MEM->RD_DEV occurs when the FIFO is full or fetched==cnt.
- RD_DEV:
  - Drive dev_out=FIFO head and dma_ack=1.
  - Each cycle with dev_ack=1 pops one word and decrements the remaining count.
  - FIFO empty with remaining>0: return to RD_MEM.
  - Remaining=0: go to DONE.
- WR_DEV (write mode):
  - dma_ack=1 while the FIFO is not full.
  - Each cycle with dev_ack=1 and dma_ack=1 pushes dev_in.
  - Go to WR_MEM when the FIFO is full or all cnt words have been received.
- WR_MEM:
  - Write FIFO words to memory until the FIFO is empty.
  - Then go to WR_DEV if words remain, else DONE.
- dma_priority=1 in these cases:
  - in RD_MEM while the FIFO is empty;
  - in WR_MEM while the FIFO is full.
- DONE: end_flag=1 for exactly one cycle, then IDLE. A new rqst is accepted the cycle after return to IDLE.
- FIFO:
  - Circular buffer with wrap-around pointers and a count of FIFO_DEPTH+1 bits.
  - Never pushes when full and never pops when empty.
  - A simultaneous push and pop cannot occur, because phases are exclusive.
- rqst is ignored outside IDLE.
- State encoding: 5 bits; IDLE=0.

Optional Feature:
- Macro DMA_STATE_DEBUG_EN.
- Defined: extra output dbg_state [4:0] carries the current state encoding, plus dbg_fifo_cnt [FIFO_DEPTH:0].
- Undefined: these ports do not exist and functional behaviour is identical.

Test Plan:
- Reset: assert reset for 1 cycle -> all outputs 0 and state IDLE next cycle; rqst held during reset is ignored.
- Read, 1 word: start_addr=0, num_words=1, rd_wr=1, memory[0]=8'hA5, dma_ready=1 -> dma_en for 1 cycle at addr 0, dma_we=00, dev_out=8'hA5 with dma_ack; on dev_ack, end_flag pulses once.
- Write, 1 word: num_words=1, rd_wr=0, dev_in=8'h3C with dev_ack -> dma_en with dma_addr=0, dma_out=8'h3C, dma_we=11, then end_flag.
- Refill: read with num_words=20, FIFO_DEPTH=4 -> 16 fetches, 16 device transfers, 4 fetches, 4 transfers; addresses 0..19 wrap to 0..19 mod 32; one end_flag.
- Stall/error: dma_ready held low for 5 cycles -> dma_en and dma_addr stable; then dma_ready=1 with dma_resp=1 -> end_flag pulse, IDLE, FIFO unchanged.
- Zero length: num_words=0 -> no dma_en, end_flag exactly 2 cycles after rqst is sampled.
